hslp_pipe_mul: RTL and testbench
================================

Name: hslp_pipe_mul

Overview:
- Parametrised, pipelined successor to the fixed 8x8 four-quadrant approximate multiplier.
- Splits each WIDTH-bit unsigned operand into high and low halves and forms four quadrant products: HH, HL (a_hi×b_lo), LH (a_lo×b_hi), LL.
- Each quadrant's approximation level is selectable at runtime through a configuration register.
- Sits between operand producers and accumulation logic behind valid/ready handshakes; a 3-stage pipeline keeps it usable at FPGA clock rates.

Parameters:
- WIDTH, 8, operand width. Must be even and ≥4. H = WIDTH/2.
- CFG_RESET, 8'h00, reset value of the configuration register (all quadrants exact).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cfg_we  input  1  write strobe for the config register
- cfg_mode  input  8  per-quadrant mode: [1:0] LL, [3:2] LH, [5:4] HL, [7:6] HH
- cfg_q  output  8  current config register value
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  downstream accepts the product
- prod  output  2*WIDTH  approximate product
- out_cnt  output  CNT_W  number of products delivered; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, prod=0, out_cnt=0, cfg_q=CFG_RESET, all stage valids=0.
  - in_ready follows its equation and is 1 immediately after reset.
- Config register:
  - Loads cfg_mode on the clk edge where cfg_we=1.
  - A transaction accepted on that same edge uses the old value.
  - The mode is captured with each transaction in S1, so later config writes never affect in-flight data.
- Quadrant mode m (0..3), clamped to H-1 if m ≥ H:
  - Both H-bit half-operands of that quadrant have their low m bits forced to 0.
  - The truncated halves are then multiplied exactly, giving a 2H-bit result.
  - m=0 is exact.
- Pipeline:
  - S1 registers a, b and the mode.
  - S2 registers the four quadrant products.
  - S3 registers prod = (HH<<WIDTH) + ((HL+LH)<<H) + LL.
  - Sum is computed at full 2*WIDTH width. No overflow is possible, since each quadrant is ≤ its exact value.
- Handshake:
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - The whole pipeline shifts one stage when adv=1; otherwise all stages hold.
  - Bubbles are not collapsed.
  - Accept when in_valid && in_ready.
  - Latency: 3 cycles from accept to out_valid, with no stalls.
  - Throughput: 1 per cycle while out_ready=1.
- Outputs while stalled:
  - While out_valid=1 and out_ready=0, prod and out_valid stay stable.
  - in_valid with in_ready=0 is ignored; the producer must hold its data.
- Counter:
  - out_cnt increments on each cycle with out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0.
- Ordering: results leave in acceptance order. There is no drop or duplication under any pattern of in_valid/out_ready.
- Reset mid-operation: all in-flight transactions are discarded, with no partial output.

Test Plan:
1. Exact, WIDTH=8, cfg 0x00: a=0xFF, b=0xFF accepted at cycle t → prod=0xFE01 (65025), out_valid=1 at t+3.
2. Per-quadrant truncation, WIDTH=8: a=0xB7, b=0x5D.
   - cfg 0x00 → prod=17019.
   - cfg 0x02 (LL m=2; LL=4×12=48 instead of 91) → prod=16976.
3. Backpressure: stream 4 pairs (1×1, 2×3, 4×5, 6×7) with out_ready=0 for 5 cycles.
   - in_ready drops once out_valid=1.
   - Output holds at 1 while stalled.
   - After release, outputs are 1, 6, 20, 42 in order.
   - out_cnt=4.
4. Config race: cfg_we with 0xFF on the same edge as accepting a=0xFF, b=0xFF (prior cfg 0x00) → that result is 65025. The next pair 0xFF×0xFF gives each quadrant 8×8=64, so prod=(64<<8)+((64+64)<<4)+64=18496.
5. Reset mid-stream: assert rst_n=0 with 3 transactions in flight → out_valid=0, out_cnt=0, cfg_q=CFG_RESET next sample. No stale output after release.
6. WIDTH=16, cfg 0x00: random 1000 pairs with random out_ready → every prod equals a×b, and out_cnt equals the handshake count modulo 2^16.

Source files
------------

// File: rtl/hslp_pipe_mul.sv
// Pipelined four-quadrant approximate multiplier with per-quadrant truncation
// selectable at runtime, behind valid/ready handshakes on both sides.
module hslp_pipe_mul #(
  parameter int         WIDTH     = 8,
  parameter logic [7:0] CFG_RESET = 8'h00,
  parameter int         CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_mode,
  output logic [7:0]           cfg_q,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic [CNT_W-1:0]     out_cnt
);

  localparam int H = WIDTH / 2;

  logic               adv;
  logic [7:0]         cfg_r;

  logic               s1_v;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [7:0]         s1_mode;

  logic               s2_v;
  logic [WIDTH-1:0]   s2_hh;
  logic [WIDTH-1:0]   s2_hl;
  logic [WIDTH-1:0]   s2_lh;
  logic [WIDTH-1:0]   s2_ll;

  logic [WIDTH-1:0]   hh_n;
  logic [WIDTH-1:0]   hl_n;
  logic [WIDTH-1:0]   lh_n;
  logic [WIDTH-1:0]   ll_n;
  logic [2*WIDTH-1:0] sum_n;

  logic               ov_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [CNT_W-1:0]   cnt_r;

  // A mode larger than the half width would zero the whole half; cap it.
  function automatic logic [1:0] clamp_mode(input logic [1:0] m);
    if (int'(m) > H - 1) return 2'(H - 1);
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] qprod(input logic [H-1:0] x,
                                             input logic [H-1:0] y,
                                             input logic [1:0]   m);
    logic [H-1:0] mask;
    logic [H-1:0] xt;
    logic [H-1:0] yt;
    mask = {H{1'b1}} << clamp_mode(m);
    xt   = x & mask;
    yt   = y & mask;
    return {{H{1'b0}}, xt} * {{H{1'b0}}, yt};
  endfunction

  // Whole pipeline moves in lockstep; bubbles are kept, not collapsed.
  assign adv      = !ov_r || out_ready;
  assign in_ready = adv;
  assign cfg_q    = cfg_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_r <= CFG_RESET;
    end else if (cfg_we) begin
      cfg_r <= cfg_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_mode <= cfg_r;
      end
    end
  end

  assign hh_n = qprod(s1_a[WIDTH-1:H], s1_b[WIDTH-1:H], s1_mode[7:6]);
  assign hl_n = qprod(s1_a[WIDTH-1:H], s1_b[H-1:0],     s1_mode[5:4]);
  assign lh_n = qprod(s1_a[H-1:0],     s1_b[WIDTH-1:H], s1_mode[3:2]);
  assign ll_n = qprod(s1_a[H-1:0],     s1_b[H-1:0],     s1_mode[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_hh <= '0;
      s2_hl <= '0;
      s2_lh <= '0;
      s2_ll <= '0;
    end else if (adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_hh <= hh_n;
        s2_hl <= hl_n;
        s2_lh <= lh_n;
        s2_ll <= ll_n;
      end
    end
  end

  assign sum_n = {s2_hh, {WIDTH{1'b0}}}
               + ({{WIDTH{1'b0}}, s2_hl} << H)
               + ({{WIDTH{1'b0}}, s2_lh} << H)
               + {{WIDTH{1'b0}}, s2_ll};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_r   <= 1'b0;
      prod_r <= '0;
    end else if (adv) begin
      ov_r <= s2_v;
      if (s2_v) begin
        prod_r <= sum_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (ov_r && out_ready) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign out_valid = ov_r;
  assign prod      = prod_r;
  assign out_cnt   = cnt_r;

endmodule

// File: tb/tb_hslp_pipe_mul.sv
// Bench for hslp_pipe_mul: directed table and sequences on an 8-bit instance,
// randomized handshake traffic on a 16-bit instance against a quadrant model.
module tb_hslp_pipe_mul;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cfg_we8, in_valid8, out_ready8;
  logic [7:0]  cfg_mode8, cfg_q8, a8, b8;
  logic        in_ready8, out_valid8;
  logic [15:0] prod8;
  logic [2:0]  out_cnt8;

  logic        cfg_we16, in_valid16, out_ready16;
  logic [7:0]  cfg_mode16, cfg_q16;
  logic [15:0] a16, b16;
  logic        in_ready16, out_valid16;
  logic [31:0] prod16;
  logic [15:0] out_cnt16;

  hslp_pipe_mul #(.WIDTH(8), .CFG_RESET(8'h00), .CNT_W(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we8), .cfg_mode(cfg_mode8),
    .cfg_q(cfg_q8), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8),
    .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .prod(prod8),
    .out_cnt(out_cnt8));

  hslp_pipe_mul #(.WIDTH(16), .CFG_RESET(8'h00), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we16), .cfg_mode(cfg_mode16),
    .cfg_q(cfg_q16), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16),
    .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .prod(prod16),
    .out_cnt(out_cnt16));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  cfg;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[10];

  logic [15:0]       got8[$];
  longint unsigned   exp16[$];
  logic [7:0]        cfg16;
  int                hs16, sent16;
  bit                acc16;
  bit                pv16, pr16;
  logic [31:0]       pp16;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quadrant model straight from the arithmetic definition.
  function automatic longint unsigned approx(input longint unsigned x, input longint unsigned y,
                                             input int w, input logic [7:0] c);
    int h;
    longint unsigned xh, xl, yh, yl, q[4];
    int m[4];
    h  = w / 2;
    xh = x / (64'd1 << h);  xl = x % (64'd1 << h);
    yh = y / (64'd1 << h);  yl = y % (64'd1 << h);
    for (int i = 0; i < 4; i++) begin
      m[i] = int'(c[2*i +: 2]);
      if (m[i] >= h) m[i] = h - 1;
    end
    q[0] = ((xl >> m[0]) << m[0]) * ((yl >> m[0]) << m[0]);
    q[1] = ((xl >> m[1]) << m[1]) * ((yh >> m[1]) << m[1]);
    q[2] = ((xh >> m[2]) << m[2]) * ((yl >> m[2]) << m[2]);
    q[3] = ((xh >> m[3]) << m[3]) * ((yh >> m[3]) << m[3]);
    return (q[3] << w) + ((q[2] + q[1]) << h) + q[0];
  endfunction

  function automatic logic [15:0] pop8();
    if (got8.size() == 0) return 'x;
    return got8.pop_front();
  endfunction

  task automatic wait_got8(input int n, input string name);
    for (int k = 0; k < 30 && got8.size() < n; k++) tick();
    if (got8.size() < n) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, got %0d results, expected %0d", name, got8.size(), n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) got8.delete();
    else if (out_valid8 && out_ready8) got8.push_back(prod8);
  end

  always @(negedge clk) begin
    acc16 = 1'b0;
    if (!rst_n) begin
      exp16.delete();
      hs16 = 0;
      cfg16 = 8'h00;
      pv16 = 1'b0;
    end else begin
      if (pv16 && !pr16) begin
        check("r16_stall_valid", out_valid16, 1'b1);
        check("r16_stall_prod", prod16, pp16);
      end
      if (out_valid16 && out_ready16) begin
        hs16++;
        if (exp16.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL r16_extra: got product %0h, expected none", prod16);
        end else begin
          check("r16_prod", prod16, exp16.pop_front());
        end
      end
      if (in_valid16 && in_ready16) begin
        exp16.push_back(approx(a16, b16, 16, cfg16));
        sent16++;
        acc16 = 1'b1;
      end
      if (cfg_we16) cfg16 = cfg_mode16;
      pv16 = out_valid16;
      pr16 = out_ready16;
      pp16 = prod16;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hFF, 8'hFF, 8'h00, 16'd65025};
    tbl[1] = '{8'hB7, 8'h5D, 8'h00, 16'd17019};
    tbl[2] = '{8'hB7, 8'h5D, 8'h02, 16'd16976};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 16'd18496};
    tbl[4] = '{8'h00, 8'hAB, 8'h00, 16'd0};
    tbl[5] = '{8'h12, 8'h34, 8'h00, 16'd936};
    tbl[6] = '{8'h12, 8'h34, 8'h40, 16'd168};
    tbl[7] = '{8'h12, 8'h34, 8'h30, 16'd872};
    tbl[8] = '{8'hFF, 8'hFF, 8'h03, 16'd64864};
    tbl[9] = '{8'hFF, 8'hFF, 8'h0C, 16'd62449};

    rst_n = 1'b0;
    cfg_we8 = 0; cfg_mode8 = 0; in_valid8 = 0; a8 = 0; b8 = 0; out_ready8 = 0;
    cfg_we16 = 0; cfg_mode16 = 0; in_valid16 = 0; a16 = 0; b16 = 0; out_ready16 = 0;
    sent16 = 0;
    #1;
    check("rst_out_valid", out_valid8, 1'b0);
    check("rst_prod", prod8, 16'h0);
    check("rst_out_cnt", out_cnt8, 3'd0);
    check("rst_cfg_q", cfg_q8, 8'h00);
    check("rst_in_ready", in_ready8, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Exact multiply and three-cycle latency
    out_ready8 = 1; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1;
    tick();
    in_valid8 = 0;
    check("lat_c1", out_valid8, 1'b0);
    tick();
    check("lat_c2", out_valid8, 1'b0);
    tick();
    check("lat_c3", out_valid8, 1'b1);
    check("lat_prod", prod8, 16'hFE01);
    repeat (3) tick();

    // Table of operand / config combinations
    for (int i = 0; i < 10; i++) begin
      cfg_we8 = 1; cfg_mode8 = tbl[i].cfg;
      tick();
      cfg_we8 = 0;
      check("tbl_cfg_q", cfg_q8, tbl[i].cfg);
      got8.delete();
      a8 = tbl[i].a; b8 = tbl[i].b; in_valid8 = 1;
      tick();
      in_valid8 = 0;
      wait_got8(1, "tbl_wait");
      check($sformatf("tbl_%0d", i), pop8(), tbl[i].exp);
    end

    // Backpressure: four pairs, output stalled five cycles
    do_reset();
    out_ready8 = 0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'(2 * i + (i == 0 ? 1 : 0)); b8 = 8'(2 * i + 1); in_valid8 = 1;
      tick();
    end
    check("bp_valid_up", out_valid8, 1'b1);
    check("bp_in_ready_low", in_ready8, 1'b0);
    a8 = 8'd6; b8 = 8'd7;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", out_valid8, 1'b1);
      check("bp_hold_prod", prod8, 16'd1);
      check("bp_hold_ready", in_ready8, 1'b0);
      tick();
    end
    out_ready8 = 1;
    tick();
    in_valid8 = 0;
    wait_got8(4, "bp_wait");
    tick();
    check("bp_res0", pop8(), 16'd1);
    check("bp_res1", pop8(), 16'd6);
    check("bp_res2", pop8(), 16'd20);
    check("bp_res3", pop8(), 16'd42);
    check("bp_cnt", out_cnt8, 3'd4);
    check("bp_no_extra", got8.size(), 0);

    // Config write on the same edge as an accept
    do_reset();
    out_ready8 = 1;
    cfg_we8 = 1; cfg_mode8 = 8'hFF; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1;
    tick();
    cfg_we8 = 0;
    tick();
    in_valid8 = 0;
    wait_got8(2, "race_wait");
    check("race_old_cfg", pop8(), 16'd65025);
    check("race_new_cfg", pop8(), 16'd18496);
    check("race_cfg_q", cfg_q8, 8'hFF);

    // Reset with three transactions in flight
    do_reset();
    cfg_we8 = 1; cfg_mode8 = 8'h55;
    tick();
    cfg_we8 = 0;
    out_ready8 = 0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'(i + 3); b8 = 8'(i + 5); in_valid8 = 1;
      tick();
    end
    in_valid8 = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid8, 1'b0);
    check("mid_rst_cnt", out_cnt8, 3'd0);
    check("mid_rst_cfg", cfg_q8, 8'h00);
    check("mid_rst_prod", prod8, 16'h0);
    tick();
    rst_n = 1'b1;
    out_ready8 = 1;
    got8.delete();
    repeat (6) tick();
    check("mid_rst_no_stale", got8.size(), 0);
    check("mid_rst_idle", out_valid8, 1'b0);

    // Counter wrap on the 3-bit instance
    got8.delete();
    for (int i = 0; i < 10; i++) begin
      a8 = 8'(i); b8 = 8'd3; in_valid8 = 1;
      tick();
    end
    in_valid8 = 0;
    repeat (5) tick();
    check("wrap_count", got8.size(), 10);
    check("wrap_cnt", out_cnt8, 3'd2);
    for (int i = 0; i < 10; i++) check("wrap_order", pop8(), 16'(3 * i));

    // 16-bit random traffic, exact mode, then random config writes
    for (int ph = 0; ph < 2; ph++) begin
      int target;
      target = (ph == 0) ? 1000 : 1300;
      for (int cyc = 0; cyc < 20000 && sent16 < target; cyc++) begin
        if (!in_valid16 || acc16) begin
          in_valid16 = ($urandom_range(0, 3) != 0);
          a16 = 16'($urandom);
          b16 = 16'($urandom);
        end
        out_ready16 = ($urandom_range(0, 2) != 0);
        cfg_we16 = (ph == 1) && ($urandom_range(0, 9) == 0);
        cfg_mode16 = 8'($urandom);
        tick();
      end
      in_valid16 = 0;
      cfg_we16 = 0;
      check("r16_sent", sent16 >= target, 1'b1);
    end
    out_ready16 = 1;
    for (int k = 0; k < 50 && exp16.size() != 0; k++) tick();
    tick();
    check("r16_drain", exp16.size(), 0);
    check("r16_cnt", out_cnt16, 16'(hs16 % 65536));
    check("r16_idle", out_valid16, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
